// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO PMOS array driver: code width, array size,
// driver FSM states and the per-cycle slew clamp.
package ldo_pkg;

  localparam int CODE_W  = 8;
  localparam int N_UNITS = (1 << CODE_W) - 1;

  typedef enum logic [1:0] {
    SLEW   = 2'd0,
    SETTLE = 2'd1,
    STABLE = 2'd2
  } ldo_state_e;

  // Smaller of the remaining distance and the allowed per-cycle step.
  function automatic logic [CODE_W-1:0] clamp_step(input logic [CODE_W:0] diff,
                                                   input logic [CODE_W:0] step);
    if (diff > step) return step[CODE_W-1:0];
    return diff[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/ldo_therm_decoder.sv
// Count-to-thermometer decode for the PMOS array; bit i is low (cell on) when i < count.
module ldo_therm_decoder
  import ldo_pkg::*;
(
  input  logic [CODE_W-1:0]  count_i,
  output logic [N_UNITS-1:0] therm_n_o
);

  always_comb begin
    therm_n_o = '1;
    for (int i = 0; i < N_UNITS; i++) begin
      therm_n_o[i] = !(i < int'(count_i));
    end
  end

endmodule

// File: rtl/ldo_pmos_driver.sv
// Slew-limited thermometer driver for the LDO PMOS array with settle detection.
//   state  | meaning
//   SLEW   | count moving toward target
//   SETTLE | on target, counting settle cycles
//   STABLE | on target long enough, settled asserted
module ldo_pmos_driver
  import ldo_pkg::*;
#(
  parameter int STEP          = 16,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_UNITS     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                hold,
  output logic [N_UNITS-1:0]  gate_n,
  output logic [CODE_W-1:0]   units_on,
  output logic                settled,
  output logic                slewing
);

  localparam logic [CODE_W:0]   STEP_W   = (CODE_W+1)'(STEP);
  localparam logic [CODE_W-1:0] MAX_W    = CODE_W'(MAX_UNITS);
  localparam int                CNT_W    = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CODE_W-1:0]  tgt_q, tgt_d;
  logic [CODE_W-1:0]  cur_q, cur_d;
  logic [N_UNITS-1:0] gate_n_q, gate_n_d;
  logic [CODE_W:0]    diff_up, diff_dn;
  logic [CNT_W-1:0]   cnt_q;
  ldo_state_e         state_q;
  logic               settled_q, slewing_q;
  logic               on_tgt;

  always_comb begin
    tgt_d   = (~code_in > MAX_W) ? MAX_W : ~code_in;
    diff_up = {1'b0, tgt_q} - {1'b0, cur_q};
    diff_dn = {1'b0, cur_q} - {1'b0, tgt_q};
    cur_d   = cur_q;
    if (!hold) begin
      if (tgt_q > cur_q)      cur_d = cur_q + clamp_step(diff_up, STEP_W);
      else if (tgt_q < cur_q) cur_d = cur_q - clamp_step(diff_dn, STEP_W);
    end
    on_tgt = (cur_d == tgt_q);
  end

  // Decode the next count so the gate bus leaves a flop, never a comparator.
  ldo_therm_decoder u_decoder (
    .count_i   (cur_d),
    .therm_n_o (gate_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q     <= '0;
      cur_q     <= '0;
      gate_n_q  <= '1;
      state_q   <= SETTLE;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      slewing_q <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      gate_n_q  <= gate_n_d;
      slewing_q <= !hold && !on_tgt;
      if (hold) begin
        settled_q <= 1'b0;
      end else if (!on_tgt) begin
        state_q   <= SLEW;
        cnt_q     <= '0;
        settled_q <= 1'b0;
      end else begin
        case (state_q)
          SLEW: begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            settled_q <= 1'b0;
          end
          SETTLE: begin
            if (cnt_q == CNT_LAST) begin
              state_q   <= STABLE;
              settled_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + 1'b1;
              settled_q <= 1'b0;
            end
          end
          STABLE: begin
            settled_q <= 1'b1;
          end
          default: begin
            state_q   <= SLEW;
            cnt_q     <= '0;
            settled_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gate_n   = gate_n_q;
  assign units_on = cur_q;
  assign settled  = settled_q;
  assign slewing  = slewing_q;

endmodule

// File: tb/tb_ldo_pmos_driver.sv
// Bench for ldo_pmos_driver: a full-range instance and one clamped to 200 cells,
// both checked against a cycle-level behavioural model.
module tb_ldo_pmos_driver;

  localparam int STEP = 16;
  localparam int SC   = 3;
  localparam int MAXV [2] = '{255, 200};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic [7:0]        code_in = 8'hFF;
  logic [1:0][254:0] gate_n;
  logic [1:0][7:0]   units_on;
  logic [1:0]        settled;
  logic [1:0]        slewing;

  int checks = 0;
  int errors = 0;

  int m_tgt [2];
  int m_cur [2];
  int m_run [2];
  bit m_set [2];
  bit m_slew [2];
  bit m_held;

  always #5 clk = ~clk;

  ldo_pmos_driver #(.STEP(STEP), .SETTLE_CYCLES(SC), .MAX_UNITS(255)) dut_full (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .hold(hold),
    .gate_n(gate_n[0]), .units_on(units_on[0]), .settled(settled[0]), .slewing(slewing[0])
  );

  ldo_pmos_driver #(.STEP(STEP), .SETTLE_CYCLES(SC), .MAX_UNITS(200)) dut_clamp (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .hold(hold),
    .gate_n(gate_n[1]), .units_on(units_on[1]), .settled(settled[1]), .slewing(slewing[1])
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Cells below the count are on (0), the rest off (1).
  function automatic logic [254:0] exp_gate(input int c);
    logic [254:0] ones;
    ones = '1;
    return ones << c;
  endfunction

  // Reset counts as arrival at target 0, so settle needs SC further on-target edges.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_tgt[k] = 0; m_cur[k] = 0; m_run[k] = 1; m_set[k] = 0; m_slew[k] = 0;
    end
    m_held = 0;
  endtask

  // One clock edge: move toward the previously registered target, then sample the new one.
  // settled means the count has matched the target on SC edges after the edge it arrived.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int t;
      t = m_tgt[k];
      if (!hold) begin
        if (m_cur[k] < t)      m_cur[k] += imin(STEP, t - m_cur[k]);
        else if (m_cur[k] > t) m_cur[k] -= imin(STEP, m_cur[k] - t);
      end
      if (hold) m_set[k] = 0;
      else if (m_cur[k] != t) begin m_run[k] = 0; m_set[k] = 0; end
      else begin m_run[k]++; m_set[k] = (m_run[k] >= SC + 1); end
      m_slew[k] = !hold && (m_cur[k] != t);
      m_tgt[k] = imin(255 - int'(code_in), MAXV[k]);
    end
    m_held = hold;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_and_wait(input logic [7:0] code, input int n);
    code_in = code;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; code_in = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (units_on[k] !== 8'd0) begin errors++; $display("FAIL reset_units[%0d] got %0d want 0", k, units_on[k]); end
      checks++; if (gate_n[k] !== exp_gate(0)) begin errors++; $display("FAIL reset_gate[%0d] got %h", k, gate_n[k]); end
      checks++; if (settled[k] !== 1'b0) begin errors++; $display("FAIL reset_settled[%0d] got %b want 0", k, settled[k]); end
      checks++; if (slewing[k] !== 1'b0) begin errors++; $display("FAIL reset_slewing[%0d] got %b want 0", k, slewing[k]); end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++; if (settled[0] !== (e == 3)) begin errors++; $display("FAIL reset_settle_edge%0d got %b want %b", e, settled[0], (e == 3)); end
      checks++; if (units_on[0] !== 8'd0 || gate_n[0] !== exp_gate(0)) begin errors++; $display("FAIL reset_idle_edge%0d units %0d", e, units_on[0]); end
    end
  endtask

  task automatic test_ramp();
    code_in = 8'h7F;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i >= 1 && i <= 8) begin
        checks++; if (units_on[0] !== 8'(16 * i)) begin errors++; $display("FAIL ramp_seq step%0d got %0d want %0d", i, units_on[0], 16 * i); end
      end
      checks++; if (units_on[0] !== 8'(m_cur[0])) begin errors++; $display("FAIL ramp_units got %0d want %0d", units_on[0], m_cur[0]); end
      checks++; if (gate_n[0] !== exp_gate(m_cur[0])) begin errors++; $display("FAIL ramp_gate got %h want %h", gate_n[0], exp_gate(m_cur[0])); end
      checks++; if (settled[0] !== m_set[0]) begin errors++; $display("FAIL ramp_settled got %b want %b", settled[0], m_set[0]); end
      checks++; if (slewing[0] !== m_slew[0]) begin errors++; $display("FAIL ramp_slewing got %b want %b", slewing[0], m_slew[0]); end
    end
    checks++; if (settled[0] !== 1'b1) begin errors++; $display("FAIL ramp_final_settled got %b want 1", settled[0]); end
    checks++; if (gate_n[0][127:0] !== '0) begin errors++; $display("FAIL ramp_gate_low got %h want 0", gate_n[0][127:0]); end
    checks++; if (gate_n[0][254:128] !== '1) begin errors++; $display("FAIL ramp_gate_high got %h want all ones", gate_n[0][254:128]); end
  endtask

  // The new code is applied one cycle ahead so the target is already 32 when the count shows 64.
  task automatic test_reverse();
    bit ok;
    int lo, hi;
    drive_and_wait(8'hFF, 30);
    code_in = 8'h7F;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (units_on[0] == 8'd48) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL reverse_reach48 timeout got %0d want 48", units_on[0]); end
    code_in = 8'hDF;
    lo = 255; hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lo = imin(lo, int'(units_on[0]));
      hi = (int'(units_on[0]) > hi) ? int'(units_on[0]) : hi;
      if (i < 3) begin
        checks++; if (units_on[0] !== 8'(64 - 16 * i)) begin errors++; $display("FAIL reverse_seq%0d got %0d want %0d", i, units_on[0], 64 - 16 * i); end
      end
      checks++; if (units_on[0] !== 8'(m_cur[0]) || settled[0] !== m_set[0]) begin errors++; $display("FAIL reverse_model units %0d/%0d settled %b/%b", units_on[0], m_cur[0], settled[0], m_set[0]); end
    end
    checks++; if (lo < 32 || hi > 64) begin errors++; $display("FAIL reverse_range got [%0d,%0d] want within [32,64]", lo, hi); end
  endtask

  task automatic test_clamp();
    code_in = 8'h00;
    for (int i = 0; i < 25; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++; if (units_on[k] !== 8'(m_cur[k]) || gate_n[k] !== exp_gate(m_cur[k])) begin errors++; $display("FAIL clamp_model[%0d] units %0d want %0d", k, units_on[k], m_cur[k]); end
      end
    end
    checks++; if (units_on[1] !== 8'd200) begin errors++; $display("FAIL clamp_units got %0d want 200", units_on[1]); end
    checks++; if (settled[1] !== 1'b1) begin errors++; $display("FAIL clamp_settled got %b want 1", settled[1]); end
    checks++; if (gate_n[1][254:200] !== '1) begin errors++; $display("FAIL clamp_gate_off got %h want all ones", gate_n[1][254:200]); end
    checks++; if (units_on[0] !== 8'd255) begin errors++; $display("FAIL clamp_full_units got %0d want 255", units_on[0]); end
  endtask

  task automatic test_hold();
    bit ok;
    drive_and_wait(8'hFF, 30);
    code_in = 8'h7F;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (units_on[0] == 8'd80) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL hold_reach80 timeout got %0d want 80", units_on[0]); end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (units_on[0] !== 8'd80) begin errors++; $display("FAIL hold_frozen got %0d want 80", units_on[0]); end
      checks++; if (settled[0] !== 1'b0) begin errors++; $display("FAIL hold_settled got %b want 0", settled[0]); end
      checks++; if (gate_n[0] !== exp_gate(m_cur[0])) begin errors++; $display("FAIL hold_gate got %h", gate_n[0]); end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (units_on[0] !== 8'(96 + 16 * i)) begin errors++; $display("FAIL hold_resume%0d got %0d want %0d", i, units_on[0], 96 + 16 * i); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    drive_and_wait(8'hFF, 30);
    code_in = 8'h7F;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (units_on[0] == 8'd112) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL areset_reach112 timeout got %0d want 112", units_on[0]); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (units_on[k] !== 8'd0) begin errors++; $display("FAIL areset_units[%0d] got %0d want 0", k, units_on[k]); end
      checks++; if (gate_n[k] !== exp_gate(0)) begin errors++; $display("FAIL areset_gate[%0d] got %h", k, gate_n[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++; if (units_on[0] !== 8'(m_cur[0]) || settled[0] !== m_set[0] || slewing[0] !== m_slew[0]) begin
        errors++; $display("FAIL areset_ramp units %0d/%0d settled %b/%b slewing %b/%b", units_on[0], m_cur[0], settled[0], m_set[0], slewing[0], m_slew[0]);
      end
    end
    checks++; if (units_on[0] !== 8'd128) begin errors++; $display("FAIL areset_final got %0d want 128", units_on[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) code_in = 8'($urandom);
      hold = ($urandom_range(0, 9) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++; if (units_on[k] !== 8'(m_cur[k])) begin errors++; $display("FAIL rand_units[%0d] got %0d want %0d", k, units_on[k], m_cur[k]); end
        checks++; if (gate_n[k] !== exp_gate(m_cur[k])) begin errors++; $display("FAIL rand_gate[%0d] got %h want %h", k, gate_n[k], exp_gate(m_cur[k])); end
        checks++; if (settled[k] !== m_set[k]) begin errors++; $display("FAIL rand_settled[%0d] got %b want %b", k, settled[k], m_set[k]); end
        if (!m_held) begin
          checks++; if (slewing[k] !== m_slew[k]) begin errors++; $display("FAIL rand_slewing[%0d] got %b want %b", k, slewing[k], m_slew[k]); end
        end
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reverse();
    test_clamp();
    test_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
